// File: rtl/imm_field_encoder_if.sv
// Request/response bus of imm_field_encoder: immediate request side and
// assembled-word side, each with its own valid/ready handshake.
interface imm_field_encoder_if #(
  parameter int unsigned ERR_CNT_W = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [2:0]           in_immsrc;
  logic [31:0]          in_imm;
  logic [24:0]          in_base;
  logic                 out_valid;
  logic                 out_ready;
  logic [24:0]          out_instr_31_7;
  logic                 out_err;
  logic [ERR_CNT_W-1:0] err_count;

  // Producer/consumer view (drives requests, accepts words)
  modport master (
    output in_valid, in_immsrc, in_imm, in_base, out_ready,
    input  in_ready, out_valid, out_instr_31_7, out_err, err_count
  );

  // Encoder view
  modport slave (
    input  in_valid, in_immsrc, in_imm, in_base, out_ready,
    output in_ready, out_valid, out_instr_31_7, out_err, err_count
  );
endinterface

// File: rtl/imm_field_encoder.sv
// imm_field_encoder: packs a 32-bit immediate into instruction[31:7] for the
// I/S/U/B/J formats, merging with a caller-supplied base word, and buffers
// the result in a 2-entry FIFO with valid/ready on both sides.
// Optional feature macro: IMMENC_RANGE_CHECK_EN enables range, alignment and
// U low-bit checks; without it only an illegal ImmSrc flags an error.
module imm_field_encoder #(
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  imm_field_encoder_if.slave bus
);

  localparam int unsigned WORD_W = 25;
  localparam int unsigned OCC_W  = 2;

  localparam logic [2:0] SRC_I = 3'b000;
  localparam logic [2:0] SRC_S = 3'b001;
  localparam logic [2:0] SRC_U = 3'b010;
  localparam logic [2:0] SRC_B = 3'b101;
  localparam logic [2:0] SRC_J = 3'b110;

`ifdef IMMENC_RANGE_CHECK_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif

  typedef struct packed {
    logic [WORD_W-1:0] word;
    logic              err;
  } entry_t;

  entry_t               enc_c;
  logic                 illegal_c;
  logic                 rng_bad_c;
  logic                 push_c;
  logic                 pop_c;

  entry_t               head_q, head_d;
  entry_t               tail_q, tail_d;
  logic [OCC_W-1:0]     occ_q, occ_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  // Field placement and representability check for the incoming request
  always_comb begin
    enc_c.word = bus.in_base;
    illegal_c  = 1'b0;
    rng_bad_c  = 1'b0;
    case (bus.in_immsrc)
      SRC_I: begin
        enc_c.word[24:13] = bus.in_imm[11:0];
        rng_bad_c = (bus.in_imm[31:11] != {21{1'b0}}) && (bus.in_imm[31:11] != {21{1'b1}});
      end
      SRC_S: begin
        enc_c.word[24:18] = bus.in_imm[11:5];
        enc_c.word[4:0]   = bus.in_imm[4:0];
        rng_bad_c = (bus.in_imm[31:11] != {21{1'b0}}) && (bus.in_imm[31:11] != {21{1'b1}});
      end
      SRC_U: begin
        enc_c.word[24:5] = bus.in_imm[31:12];
        rng_bad_c = (bus.in_imm[11:0] != 12'h000);
      end
      SRC_B: begin
        enc_c.word[24]    = bus.in_imm[12];
        enc_c.word[23:18] = bus.in_imm[10:5];
        enc_c.word[4:1]   = bus.in_imm[4:1];
        enc_c.word[0]     = bus.in_imm[11];
        rng_bad_c = ((bus.in_imm[31:12] != {20{1'b0}}) && (bus.in_imm[31:12] != {20{1'b1}}))
                    || bus.in_imm[0];
      end
      SRC_J: begin
        enc_c.word[24]    = bus.in_imm[20];
        enc_c.word[23:14] = bus.in_imm[10:1];
        enc_c.word[13]    = bus.in_imm[11];
        enc_c.word[12:5]  = bus.in_imm[19:12];
        rng_bad_c = ((bus.in_imm[31:20] != {12{1'b0}}) && (bus.in_imm[31:20] != {12{1'b1}}))
                    || bus.in_imm[0];
      end
      default: begin
        illegal_c = 1'b1;
      end
    endcase
    enc_c.err = illegal_c | (RANGE_EN & rng_bad_c);
  end

  assign push_c = bus.in_valid & in_ready_q;
  assign pop_c  = out_valid_q & bus.out_ready;

  // FIFO next state: head always feeds the outputs, tail is the second slot
  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    occ_d       = occ_q;
    err_cnt_d   = err_cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    if (pop_c) begin
      if (occ_q == OCC_W'(2)) begin
        head_d = tail_q;
      end else if (push_c) begin
        head_d = enc_c;
      end
    end else if (push_c) begin
      if (occ_q == OCC_W'(0)) begin
        head_d = enc_c;
      end else begin
        tail_d = enc_c;
      end
    end

    if (push_c && !pop_c) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (pop_c && !push_c) begin
      occ_d = occ_q - OCC_W'(1);
    end

    if (pop_c && head_q.err && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end

    in_ready_d  = (occ_d != OCC_W'(2));
    out_valid_d = (occ_d != OCC_W'(0));
  end

  // State registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      occ_q       <= '0;
      err_cnt_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      occ_q       <= occ_d;
      err_cnt_q   <= err_cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready       = in_ready_q;
  assign bus.out_valid      = out_valid_q;
  assign bus.out_instr_31_7 = head_q.word;
  assign bus.out_err        = head_q.err;
  assign bus.err_count      = err_cnt_q;

endmodule

// File: tb/tb_imm_field_encoder.sv
// Directed bench for imm_field_encoder: field placement per format, error
// flagging (build-dependent), backpressure, throughput and async reset.
module tb_imm_field_encoder;

`ifdef IMMENC_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_total;
  int   n_pass;
  int   n_acc;

  imm_field_encoder_if #(.ERR_CNT_W(8)) bus ();

  imm_field_encoder #(.ERR_CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] src, input logic [31:0] imm, input logic [24:0] base);
    bus.in_valid  = 1'b1;
    bus.in_immsrc = src;
    bus.in_imm    = imm;
    bus.in_base   = base;
  endtask

  // Present one request for one edge, then drop in_valid
  task automatic send(input logic [2:0] src, input logic [31:0] imm, input logic [24:0] base);
    drive(src, imm, base);
    step();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    n_acc   = 0;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_immsrc = 3'b000;
    bus.in_imm    = 32'h0;
    bus.in_base   = 25'h0;
    bus.out_ready = 1'b1;
    step();
    step();

    chk("rst_in_ready",  32'(bus.in_ready), 32'h1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_word",      32'(bus.out_instr_31_7), 32'h0);
    chk("rst_err",       32'(bus.out_err), 32'h0);
    chk("rst_err_count", 32'(bus.err_count), 32'h0);
    rst = 1'b0;
    step();

    // I format, -1
    send(3'b000, 32'hFFFF_FFFF, 25'h0);
    chk("i_valid", 32'(bus.out_valid), 32'h1);
    chk("i_word",  32'(bus.out_instr_31_7), 32'h1FF_E000);
    chk("i_err",   32'(bus.out_err), 32'h0);
    step();
    chk("i_drained", 32'(bus.out_valid), 32'h0);

    // U format with base low bits
    send(3'b010, 32'h1234_5000, 25'h000_001F);
    chk("u_word", 32'(bus.out_instr_31_7), 32'h024_68BF);
    chk("u_err",  32'(bus.out_err), 32'h0);
    step();

    // B format, imm[11] lands in bit 0
    send(3'b101, 32'h0000_0800, 25'h0);
    chk("b_word", 32'(bus.out_instr_31_7), 32'h000_0001);
    chk("b_err",  32'(bus.out_err), 32'h0);
    step();

    // J format, imm[11] lands in bit 13
    send(3'b110, 32'h0000_0800, 25'h0);
    chk("j_word", 32'(bus.out_instr_31_7), 32'h000_2000);
    chk("j_err",  32'(bus.out_err), 32'h0);
    step();
    chk("cnt_after_clean", 32'(bus.err_count), 32'h0);

    // S format, 2048 is out of range
    send(3'b001, 32'h0000_0800, 25'h0);
    chk("s_word", 32'(bus.out_instr_31_7), 32'h100_0000);
    chk("s_err",  32'(bus.out_err), 32'(RC));
    step();
    chk("s_cnt", 32'(bus.err_count), RC ? 32'd1 : 32'd0);

    // B format, odd offset
    send(3'b101, 32'h0000_0003, 25'h0);
    chk("b3_word", 32'(bus.out_instr_31_7), 32'h000_0002);
    chk("b3_err",  32'(bus.out_err), 32'(RC));
    step();
    chk("b3_cnt", 32'(bus.err_count), RC ? 32'd2 : 32'd0);

    // Illegal ImmSrc: base passes through, always an error
    send(3'b011, 32'hDEAD_BEEF, 25'h0AB_CDEF);
    chk("ill_word", 32'(bus.out_instr_31_7), 32'h0AB_CDEF);
    chk("ill_err",  32'(bus.out_err), 32'h1);
    step();
    chk("ill_cnt", 32'(bus.err_count), RC ? 32'd3 : 32'd1);
    step();
    chk("idle_cnt_hold", 32'(bus.err_count), RC ? 32'd3 : 32'd1);
    chk("idle_valid",    32'(bus.out_valid), 32'h0);

    // Backpressure: offer three words, only two fit
    bus.out_ready = 1'b0;
    drive(3'b000, 32'h1, 25'h0);
    if (bus.in_ready) n_acc++;
    step();
    drive(3'b000, 32'h2, 25'h0);
    if (bus.in_ready) n_acc++;
    step();
    drive(3'b000, 32'h3, 25'h0);
    if (bus.in_ready) n_acc++;
    step();
    bus.in_valid = 1'b0;
    chk("bp_accepted", 32'(n_acc), 32'd2);
    chk("bp_in_ready", 32'(bus.in_ready), 32'h0);
    chk("bp_head",     32'(bus.out_instr_31_7), 32'h000_2000);
    step();
    chk("bp_hold", 32'(bus.out_instr_31_7), 32'h000_2000);
    bus.out_ready = 1'b1;
    step();
    chk("bp_second",   32'(bus.out_instr_31_7), 32'h000_4000);
    chk("bp_ready_up", 32'(bus.in_ready), 32'h1);
    step();
    chk("bp_empty", 32'(bus.out_valid), 32'h0);

    // Throughput: one word per cycle with out_ready high
    drive(3'b000, 32'h4, 25'h0);
    step();
    chk("tp_w0", 32'(bus.out_instr_31_7), 32'h000_8000);
    drive(3'b000, 32'h5, 25'h0);
    step();
    chk("tp_w1", 32'(bus.out_instr_31_7), 32'h000_A000);
    drive(3'b000, 32'h6, 25'h0);
    step();
    chk("tp_w2",    32'(bus.out_instr_31_7), 32'h000_C000);
    chk("tp_ready", 32'(bus.in_ready), 32'h1);
    bus.in_valid = 1'b0;
    step();
    chk("tp_empty", 32'(bus.out_valid), 32'h0);

    // Reset with a full buffer
    bus.out_ready = 1'b0;
    send(3'b011, 32'h0, 25'h155_5555);
    send(3'b000, 32'h7, 25'h0);
    chk("pre_rst_full", 32'(bus.in_ready), 32'h0);
    rst = 1'b1;
    #1;
    chk("arst_valid",     32'(bus.out_valid), 32'h0);
    chk("arst_err_count", 32'(bus.err_count), 32'h0);
    chk("arst_in_ready",  32'(bus.in_ready), 32'h1);
    chk("arst_word",      32'(bus.out_instr_31_7), 32'h0);
    step();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    step();
    step();
    chk("post_rst_no_stale", 32'(bus.out_valid), 32'h0);
    chk("post_rst_cnt",      32'(bus.err_count), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/imm_field_encoder.md
# imm_field_encoder

Packs a 32-bit immediate back into the `instruction[31:7]` bit positions for the I, S, U, B and J formats, using the same ImmSrc encoding and bit placement that the datapath's immediate decoder expects. Non-immediate bits (rd, funct3, rs1, rs2, funct7) come from a caller-supplied base word and pass through unchanged. The block sits in the program loader / self-test path and feeds assembled instruction fields toward instruction memory. It uses valid/ready on both sides with a 2-entry output buffer, and counts range/alignment violations.

## Interface
- ERR_CNT_W, 8, width of the saturating error counter
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  request present
- in_ready  out  1  block can accept a request this cycle
- in_immsrc  in  3  000 I, 001 S, 010 U, 101 B, 110 J; others illegal
- in_imm  in  32  immediate value, two's complement
- in_base  in  25  `instruction[31:7]` with the immediate bits don't-care
- out_valid  out  1  assembled word available
- out_ready  in  1  consumer accepts the word
- out_instr_31_7  out  25  assembled `instruction[31:7]`
- out_err  out  1  range, alignment or ImmSrc violation for this word
- err_count  out  ERR_CNT_W  count of words emitted with out_err=1, saturating

## Operation
- Field placement uses bit indices `[24:0]` of `instruction[31:7]`. All bits not listed below come from in_base.
  - I: imm[11:0] → [24:13]
  - S: imm[11:5] → [24:18]; imm[4:0] → [4:0]
  - U: imm[31:12] → [24:5]
  - B: imm[12] → [24]; imm[10:5] → [23:18]; imm[4:1] → [4:1]; imm[11] → [0]
  - J: imm[20] → [24]; imm[10:1] → [23:14]; imm[11] → [13]; imm[19:12] → [12:5]
  - Illegal ImmSrc: word = in_base unchanged; out_err=1.
- Checks (macro-controlled, see Configuration). out_err is set when the immediate cannot be represented:
  - I/S: value outside −2048..2047.
  - B: value outside −4096..4094, or imm[0]=1.
  - J: value outside −2^20..2^20−2, or imm[0]=1.
  - U: imm[11:0]≠0.
- A word that fails a check is still emitted, carrying the truncated fields and out_err=1.
- Buffer: 2-entry FIFO of {word, err}. Push on in_valid&in_ready; pop on out_valid&out_ready.
- in_ready is registered and equals (occupancy < 2) for the next cycle.
- err_count increments on every pop with err=1. It saturates at all-ones.

## Timing
- Reset values: in_ready=1, out_valid=0, out_instr_31_7=0, out_err=0, err_count=0, occupancy=0.
- Latency: a word accepted at edge N appears on the outputs after edge N, when the buffer was empty.
- Throughput: 1 word/cycle when out_ready is held high.
- Outputs are driven from the FIFO head register; there is no combinational path from in_* to out_*.
- Occupancy 1 with simultaneous push and pop: occupancy stays 1, the head advances to the new word, order is preserved.
- Occupancy 2: in_ready=0 and no push occurs. A pop in that cycle raises in_ready on the next edge.
- Occupancy 0 with out_ready=1: no pop, and err_count is unchanged.
- out_valid=1 and out_ready=0: the head word and out_err hold stable until the pop.
- rst asserted mid-operation: buffer contents are discarded and every output returns to its reset value immediately. There is no partial-word output.

## Configuration
- IMMENC_RANGE_CHECK_EN defined: all range, alignment and U low-bit checks are active, as above.
- IMMENC_RANGE_CHECK_EN undefined:
  - Only illegal ImmSrc sets out_err.
  - Immediates are silently truncated into their fields.
  - err_count counts only illegal-ImmSrc words.

## Test plan
- I, imm=0xFFFFFFFF, base=0, out_ready=1 → next cycle out_instr_31_7=0x1FFE000, out_err=0.
- U, imm=0x12345000, base=0x000001F → 0x02468BF, out_err=0.
- B, imm=0x00000800, base=0 → 0x0000001. J, imm=0x00000800 → 0x0002000. Both with out_err=0.
- With macro defined: S, imm=0x00000800 → out_err=1, err_count=1. Then B, imm=3 → out_err=1, err_count=2. With macro undefined, the same stimulus gives out_err=0 and err_count=0.
- Backpressure: out_ready=0 while 3 requests are offered → exactly 2 accepted and in_ready=0. Release out_ready → words emerge in order and in_ready returns to 1.
- Reset while occupancy=2: rst pulse → out_valid=0, err_count=0, in_ready=1, and no stale word appears afterwards.
